mac_accum: RTL and testbench



---
 rtl/mac_pkg.sv | 22 ++
 rtl/mac_mult_stage.sv | 57 +++++
 rtl/mac_accum.sv | 47 ++++
 tb/tb_mac_accum.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants and helpers for the MAC accumulator datapath.
package mac_pkg;

    // Operand width used by the FFT butterfly datapath.
    localparam int DATA_WIDTH_DEFAULT = 4;

    // The accumulator is twice the operand width, so a full product always fits.
    function automatic int acc_width(input int w);
        return 2 * w;
    endfunction

    // Sign-extend the low w bits of v to the full 64-bit container.
    function automatic logic [63:0] sext(input logic [63:0] v, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r[i] = (i < w) ? v[i] : v[6'(w - 1)];
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_mult_stage.sv
// Registered operand capture (S1) and signed multiply (S2), with sload
// delayed alongside so it stays aligned with its product.
module mac_mult_stage
    import mac_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEFAULT
) (
    input  logic                                clk,
    input  logic                                aclr,
    input  logic                                sload,
    input  logic [data_width-1:0]               dataa,
    input  logic [data_width-1:0]               datab,
    output logic [acc_width(data_width)-1:0]    product,
    output logic                                sload_out
);

    localparam int AW = acc_width(data_width);

    logic [data_width-1:0] a_q;
    logic [data_width-1:0] b_q;
    // sload travels as a two-stage shift register matching S1 and S2.
    logic [1:0]            sload_pipe;
    logic [AW-1:0]         prod_c;

    // Both operands are sign-extended to the accumulator width first; the
    // AW-bit product modulo 2^AW then equals the exact signed product,
    // including (-2^(w-1))^2.
    assign prod_c = AW'(sext({{(64 - data_width){1'b0}}, a_q}, data_width)
                      * sext({{(64 - data_width){1'b0}}, b_q}, data_width));

    // S1: capture operands and sload; reset discards whatever is in flight.
    always_ff @(posedge clk) begin
        if (aclr) begin
            a_q           <= '0;
            b_q           <= '0;
            sload_pipe[0] <= 1'b0;
        end else begin
            a_q           <= dataa;
            b_q           <= datab;
            sload_pipe[0] <= sload;
        end
    end

    // S2: register the full product and the delayed sload.
    always_ff @(posedge clk) begin
        if (aclr) begin
            product       <= '0;
            sload_pipe[1] <= 1'b0;
        end else begin
            product       <= prod_c;
            sload_pipe[1] <= sload_pipe[0];
        end
    end

    assign sload_out = sload_pipe[1];

endmodule

// File: rtl/mac_accum.sv
// Pipelined signed multiply-accumulate: S1/S2 multiply in mac_mult_stage,
// S3 accumulator here. adder_out is the accumulator register itself.
module mac_accum
    import mac_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEFAULT
) (
    input  logic                                clk,
    input  logic                                aclr,
    input  logic                                sload,
    input  logic [data_width-1:0]               dataa,
    input  logic [data_width-1:0]               datab,
    output logic [acc_width(data_width)-1:0]    adder_out
);

    localparam int AW = acc_width(data_width);

    logic [AW-1:0] product;
    logic          sload_s2;
    logic [AW-1:0] acc;

    mac_mult_stage #(
        .data_width (data_width)
    ) u_mult (
        .clk       (clk),
        .aclr      (aclr),
        .sload     (sload),
        .dataa     (dataa),
        .datab     (datab),
        .product   (product),
        .sload_out (sload_s2)
    );

    // S3: reload on sload, otherwise add; wraps modulo 2^AW with no saturation.
    always_ff @(posedge clk) begin
        if (aclr) begin
            acc <= '0;
        end else if (sload_s2) begin
            acc <= product;
        end else begin
            acc <= acc + product;
        end
    end

    assign adder_out = acc;

endmodule

// File: tb/tb_mac_accum.sv
// Directed + randomized bench for mac_accum against a history-based
// reference model of the multiply-accumulate behaviour.
module tb_mac_accum;

    logic       clk = 1'b0;
    logic       aclr = 1'b0;
    logic       sload = 1'b0;
    logic [3:0] dataa = '0;
    logic [3:0] datab = '0;
    logic [7:0] adder_out;

    int n_vec = 0;
    int n_err = 0;

    // Per-edge history of what was presented to the unit.
    bit h_rst [0:1023];
    bit h_sl  [0:1023];
    int h_p   [0:1023];
    int e     = 0;
    int acc_m = 0;

    mac_accum #(.data_width(4)) dut (
        .clk       (clk),
        .aclr      (aclr),
        .sload     (sload),
        .dataa     (dataa),
        .datab     (datab),
        .adder_out (adder_out)
    );

    always #5 clk = ~clk;

    function automatic int sval(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    // Apply one operand set for one edge, update the model, then check.
    task automatic step(input bit r, input bit s, input logic [3:0] a,
                        input logic [3:0] b, input string tag, input int exp_const = -1);
        bit killed;
        logic [7:0] exp_m;
        logic [7:0] exp_c;
        aclr  = r;
        sload = s;
        dataa = a;
        datab = b;
        @(posedge clk);
        h_rst[e] = r;
        h_sl[e]  = s;
        h_p[e]   = sval(a) * sval(b);
        // Operands of edge e-2 reach the accumulator at edge e unless a reset
        // at e-2 or e-1 wiped them from the pipeline (then 0 is added).
        killed = 1'b1;
        if (e >= 2) killed = h_rst[e-2] || h_rst[e-1];
        if (r)                 acc_m = 0;
        else if (killed)       acc_m = acc_m;
        else if (h_sl[e-2])    acc_m = h_p[e-2];
        else                   acc_m = acc_m + h_p[e-2];
        acc_m = acc_m & 255;
        e++;
        #1;
        exp_m = 8'(acc_m);
        n_vec++;
        assert (adder_out === exp_m) else begin
            n_err++;
            $error("FAIL %s: adder_out=%h expected %h", tag, adder_out, exp_m);
        end
        if (exp_const >= 0) begin
            exp_c = exp_const[7:0];
            n_vec++;
            assert (adder_out === exp_c) else begin
                n_err++;
                $error("FAIL %s_const: adder_out=%h expected %h", tag, adder_out, exp_c);
            end
        end
    endtask

    initial begin
        // Reset with junk operands and sload high, then release with zeros.
        step(1, 1, 4'($urandom), 4'($urandom), "reset", 8'h00);
        step(1, 1, 4'($urandom), 4'($urandom), "reset", 8'h00);
        step(0, 0, 4'd0, 4'd0, "reset_rel", 8'h00);

        // Single load of 5 * -6.
        step(0, 1, 4'd5, 4'b1010, "load");
        step(0, 0, 4'd0, 4'd0, "load");
        step(0, 0, 4'd0, 4'd0, "load", 8'hE2);
        step(0, 0, 4'd0, 4'd0, "load_hold", 8'hE2);
        step(0, 0, 4'd0, 4'd0, "load_hold", 8'hE2);

        // Accumulate 3 * 2.
        step(0, 1, 4'd3, 4'd2, "accum");
        step(0, 0, 4'd3, 4'd2, "accum");
        step(0, 0, 4'd3, 4'd2, "accum", 8'h06);
        step(0, 0, 4'd3, 4'd2, "accum", 8'h0C);
        step(0, 0, 4'd3, 4'd2, "accum", 8'h12);
        step(0, 0, 4'd3, 4'd2, "accum", 8'h18);

        // Most-negative operands and modulo wrap.
        step(0, 1, 4'b1000, 4'b1000, "wrap");
        step(0, 0, 4'b1000, 4'b1000, "wrap");
        step(0, 0, 4'b1000, 4'b1000, "wrap", 8'h40);
        step(0, 0, 4'b1000, 4'b1000, "wrap", 8'h80);
        step(0, 0, 4'b1000, 4'b1000, "wrap", 8'hC0);
        step(0, 0, 4'b1000, 4'b1000, "wrap", 8'h00);

        // Reload mid-stream with -5 * -6.
        step(0, 1, 4'b1011, 4'b1010, "reload");
        step(0, 0, 4'b1011, 4'b1010, "reload");
        step(0, 0, 4'b1011, 4'b1010, "reload", 8'h1E);
        step(0, 0, 4'b1011, 4'b1010, "reload", 8'h3C);
        step(0, 1, 4'b1011, 4'b1010, "reload", 8'h5A);
        step(0, 0, 4'b1011, 4'b1010, "reload", 8'h78);
        step(0, 0, 4'b1011, 4'b1010, "reload", 8'h1E);

        // Reset in the middle of the wrap sequence.
        step(0, 1, 4'b1000, 4'b1000, "midrst");
        step(0, 0, 4'b1000, 4'b1000, "midrst");
        step(0, 0, 4'b1000, 4'b1000, "midrst", 8'h40);
        step(0, 0, 4'b1000, 4'b1000, "midrst", 8'h80);
        step(1, 0, 4'b1000, 4'b1000, "midrst_clr", 8'h00);
        step(0, 1, 4'b1000, 4'b1000, "midrst_rel", 8'h00);
        step(0, 0, 4'b1000, 4'b1000, "midrst_rel", 8'h00);
        step(0, 0, 4'b1000, 4'b1000, "midrst_first", 8'h40);

        // Randomized traffic: sparse resets, frequent reloads.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0),
                 4'($urandom), 4'($urandom), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
